// File: rtl/keccak_theta_pkg.sv
// -----------------------------------------------------------------------------
// keccak_theta_pkg
// Shared definitions for the Keccak theta stage: control-unit state encoding,
// state-array geometry constants and the mod-5 lane-coordinate step helper.
// -----------------------------------------------------------------------------
package keccak_theta_pkg;

    localparam int NUM_LANES = 25;
    localparam int LANES_X   = 5;
    localparam int LANES_Y   = 5;

    // Seven control states in a 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT      = 3'd1,
        ST_PAR_READ  = 3'd2,
        ST_PAR_ACC   = 3'd3,
        ST_UPD_READ  = 3'd4,
        ST_UPD_WRITE = 3'd5,
        ST_FINISH    = 3'd6
    } state_t;

    // Step a lane coordinate (0..4) by +1 (up=1) or -1 (up=0), wrapping mod 5.
    function automatic logic [2:0] coord_step(input logic [2:0] v, input logic up);
        logic [2:0] r;
        if (up) begin
            r = (v == 3'(LANES_X - 1)) ? 3'd0 : v + 3'd1;
        end else begin
            r = (v == 3'd0) ? 3'(LANES_X - 1) : v - 3'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/keccak_theta_cu.sv
// -----------------------------------------------------------------------------
// keccak_theta_cu
// Control unit of the theta stage: state register, next-state logic and Moore
// output decode. Sequences a parity pass (read/accumulate per lane) followed by
// an update pass (read/write per lane), then pulses done for one cycle.
//
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   start       begin request, honoured only in Idle
//   last_lane   datapath counters currently point at lane 24
//   ready       high in Idle only
//   done        one-cycle pulse in Finish
//   rd_en       source read strobe (ParRead, UpdRead)
//   wr_en       destination write strobe (UpdWrite)
//   clear       clear column parities and x/y counters (Init)
//   accumulate  fold rd_data into C[x] (ParAcc)
//   advance     step the x/y counters (ParAcc, UpdWrite)
// -----------------------------------------------------------------------------
module keccak_theta_cu
    import keccak_theta_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic last_lane,
    output logic ready,
    output logic done,
    output logic rd_en,
    output logic wr_en,
    output logic clear,
    output logic accumulate,
    output logic advance
);

    state_t state;
    state_t state_next;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output gets a default before the case so no path through
    // this block leaves a signal unassigned (which would infer a latch).
    always_comb begin
        state_next = state;
        ready      = 1'b0;
        done       = 1'b0;
        rd_en      = 1'b0;
        wr_en      = 1'b0;
        clear      = 1'b0;
        accumulate = 1'b0;
        advance    = 1'b0;

        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    state_next = ST_INIT;
                end
            end
            ST_INIT: begin
                clear      = 1'b1;
                state_next = ST_PAR_READ;
            end
            ST_PAR_READ: begin
                rd_en      = 1'b1;
                state_next = ST_PAR_ACC;
            end
            ST_PAR_ACC: begin
                accumulate = 1'b1;
                advance    = 1'b1;
                // Counters wrap from lane 24 back to lane 0, so the update
                // pass starts from cleared counters without an extra state.
                state_next = last_lane ? ST_UPD_READ : ST_PAR_READ;
            end
            ST_UPD_READ: begin
                rd_en      = 1'b1;
                state_next = ST_UPD_WRITE;
            end
            ST_UPD_WRITE: begin
                wr_en      = 1'b1;
                advance    = 1'b1;
                state_next = last_lane ? ST_FINISH : ST_UPD_READ;
            end
            ST_FINISH: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: rtl/keccak_theta.sv
// -----------------------------------------------------------------------------
// keccak_theta
// Theta step of the Keccak permutation. Reads the 25-lane state from a source
// lane memory (synchronous read, latency 1), accumulates the five column
// parities C[x], then rewrites every lane as A[x,y] ^ D[x] with
// D[x] = C[x-1] ^ rotl1(C[x+1]) into the destination memory, in lane order
// 0..24. Source and destination may be the same memory: each lane is read just
// before it is written and C is complete before the update pass starts.
//
// Ports:
//   clk, reset  clock, asynchronous active-high reset
//   start       begin request, accepted only while ready=1
//   ready       high in Idle only
//   done        one-cycle pulse after the last lane is written
//   rd_en       source read strobe
//   rd_addr     source lane index (5*y + x)
//   rd_data     source lane data, valid the cycle after rd_en
//   wr_en       destination write strobe
//   wr_addr     destination lane index (5*y + x)
//   wr_data     theta result for wr_addr
// -----------------------------------------------------------------------------
module keccak_theta
    import keccak_theta_pkg::*;
#(
    parameter int W  = 64,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          ready,
    output logic          done,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    input  logic [W-1:0]  rd_data,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [W-1:0]  wr_data
);

    logic          clear;
    logic          accumulate;
    logic          advance;
    logic          last_lane;

    logic [W-1:0]  c_reg [LANES_X];
    logic [2:0]    x_cnt;
    logic [2:0]    y_cnt;
    logic [AW-1:0] lane_idx;

    logic [W-1:0]  c_prev;
    logic [W-1:0]  c_next;
    logic [W-1:0]  d_cur;

    keccak_theta_cu u_cu (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .last_lane  (last_lane),
        .ready      (ready),
        .done       (done),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .clear      (clear),
        .accumulate (accumulate),
        .advance    (advance)
    );

    // Lane index 5*y + x built from shifts and adds.
    assign lane_idx  = AW'({y_cnt, 2'b00}) + AW'(y_cnt) + AW'(x_cnt);
    assign last_lane = (lane_idx == AW'(NUM_LANES - 1));

    assign rd_addr = lane_idx;
    assign wr_addr = lane_idx;

    // x/y lane counters: x runs 0..4, y steps when x wraps. Both wrap to 0
    // after lane 24, which leaves them cleared at the end of each pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_cnt <= 3'd0;
            y_cnt <= 3'd0;
        end else if (clear) begin
            x_cnt <= 3'd0;
            y_cnt <= 3'd0;
        end else if (advance) begin
            x_cnt <= coord_step(x_cnt, 1'b1);
            if (x_cnt == 3'(LANES_X - 1)) begin
                y_cnt <= coord_step(y_cnt, 1'b1);
            end
        end
    end

    // Column parity registers. C[x] only changes during the parity pass, so it
    // is frozen for the whole update pass.
    // NOTE: this is a small register bank, not a RAM, so it takes the
    // asynchronous reset like any other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LANES_X; i++) begin
                c_reg[i] <= '0;
            end
        end else if (clear) begin
            for (int i = 0; i < LANES_X; i++) begin
                c_reg[i] <= '0;
            end
        end else if (accumulate) begin
            for (int i = 0; i < LANES_X; i++) begin
                if (x_cnt == 3'(i)) begin
                    c_reg[i] <= c_reg[i] ^ rd_data;
                end
            end
        end
    end

    // Select C[x-1] and C[x+1] (mod 5) for the current column.
    always_comb begin
        c_prev = '0;
        c_next = '0;
        for (int i = 0; i < LANES_X; i++) begin
            if (coord_step(x_cnt, 1'b0) == 3'(i)) begin
                c_prev = c_reg[i];
            end
            if (coord_step(x_cnt, 1'b1) == 3'(i)) begin
                c_next = c_reg[i];
            end
        end
    end

    // D[x] = C[x-1] ^ rotl1(C[x+1]); the MSB of C[x+1] wraps into bit 0.
    assign d_cur   = c_prev ^ {c_next[W-2:0], c_next[W-1]};
    assign wr_data = rd_data ^ d_cur;

endmodule

// File: tb/tb_keccak_theta.sv
// -----------------------------------------------------------------------------
// tb_keccak_theta
// Self-checking bench for keccak_theta. A single lane memory serves as both
// source and destination (in-place theta). Expected lanes come from a
// column-parity model of theta computed over a 25-entry array.
// -----------------------------------------------------------------------------
module tb_keccak_theta;

    localparam int W  = 64;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          ready;
    logic          done;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [W-1:0]  wr_data;

    int n_vec = 0;
    int n_err = 0;

    logic [W-1:0] mem      [25];
    logic [W-1:0] load_img [25];
    logic [W-1:0] src_img  [25];
    logic [W-1:0] exp_img  [25];
    logic         load_en = 1'b0;

    int           ncyc = 0;
    logic [AW-1:0] wq_addr [$];
    logic [W-1:0]  wq_data [$];
    int            wq_cyc  [$];
    int            rq_addr [$];
    int            done_cyc[$];
    int            last_base;

    always #5 clk = ~clk;

    keccak_theta #(.W(W), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .ready   (ready),
        .done    (done),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    // Lane memory, synchronous read with latency 1. When no read is issued the
    // read port carries garbage so that rd_data is only trusted when valid.
    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < 25; i++) mem[i] <= load_img[i];
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) rd_data <= mem[rd_addr];
        else       rd_data <= {$urandom, $urandom};
    end

    // Observation at the falling edge, away from the active edge.
    always @(negedge clk) begin
        ncyc <= ncyc + 1;
        if (wr_en) begin
            wq_addr.push_back(wr_addr);
            wq_data.push_back(wr_data);
            wq_cyc.push_back(ncyc);
        end
        if (rd_en) rq_addr.push_back(int'(rd_addr));
        if (done)  done_cyc.push_back(ncyc);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Theta reference: column parities, then D[x] = C[x-1] ^ rotl1(C[x+1]).
    task automatic compute_ref();
        logic [W-1:0] c [5];
        logic [W-1:0] d [5];
        logic [W-1:0] t;
        for (int x = 0; x < 5; x++) begin
            c[x] = '0;
            for (int y = 0; y < 5; y++) c[x] = c[x] ^ src_img[5*y + x];
        end
        for (int x = 0; x < 5; x++) begin
            t    = c[(x + 1) % 5];
            d[x] = c[(x + 4) % 5] ^ ((t << 1) | (t >> (W - 1)));
        end
        for (int i = 0; i < 25; i++) exp_img[i] = src_img[i] ^ d[i % 5];
    endtask

    task automatic load_mem();
        @(negedge clk);
        load_img = src_img;
        load_en  = 1'b1;
        @(negedge clk);
        load_en  = 1'b0;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 25; i++) src_img[i] = {$urandom, $urandom};
    endtask

    task automatic fill_zero();
        for (int i = 0; i < 25; i++) src_img[i] = '0;
    endtask

    // One full theta run from a single start pulse, checked lane by lane.
    task automatic run_case(input string tag);
        int k;
        int base;
        compute_ref();
        load_mem();
        base      = wq_addr.size();
        last_base = base;
        check({tag, "_ready_idle"}, 64'(ready), 64'd1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (!done && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_done_cycle"}, 64'(k), 64'd102);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_ready_back"}, 64'(ready), 64'd1);
        check({tag, "_num_writes"}, 64'(wq_addr.size() - base), 64'd25);
        for (int i = 0; i < 25; i++) begin
            if (base + i < wq_addr.size()) begin
                check($sformatf("%s_addr%0d", tag, i), 64'(wq_addr[base + i]), 64'(i));
                check($sformatf("%s_lane%0d", tag, i), wq_data[base + i], exp_img[i]);
                if (i > 0)
                    check($sformatf("%s_gap%0d", tag, i),
                          64'(wq_cyc[base + i] - wq_cyc[base + i - 1]), 64'd2);
            end
        end
    endtask

    initial begin
        int k;
        int rbase;
        int dbase;
        int s;

        reset = 1'b1;
        start = 1'b0;
        #1;
        check("rst_ready",   64'(ready),   64'd1);
        check("rst_done",    64'(done),    64'd0);
        check("rst_rd_en",   64'(rd_en),   64'd0);
        check("rst_wr_en",   64'(wr_en),   64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_wr_addr", 64'(wr_addr), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        fill_zero();
        run_case("zero");

        fill_zero();
        src_img[0] = 64'h1;
        run_case("bit0");
        if (last_base + 24 < wq_data.size()) begin
            check("bit0_l0",  wq_data[last_base + 0],  64'h1);
            check("bit0_l1",  wq_data[last_base + 1],  64'h1);
            check("bit0_l21", wq_data[last_base + 21], 64'h1);
            check("bit0_l4",  wq_data[last_base + 4],  64'h2);
            check("bit0_l24", wq_data[last_base + 24], 64'h2);
            check("bit0_l2",  wq_data[last_base + 2],  64'h0);
        end

        fill_zero();
        src_img[0] = 64'h8000_0000_0000_0000;
        run_case("msb");
        if (last_base + 24 < wq_data.size()) begin
            check("msb_l0",  wq_data[last_base + 0],  64'h8000_0000_0000_0000);
            check("msb_l16", wq_data[last_base + 16], 64'h8000_0000_0000_0000);
            check("msb_l9",  wq_data[last_base + 9],  64'h1);
        end

        fill_zero();
        src_img[0] = 64'hFF;
        src_img[5] = 64'hFF;
        run_case("cancel");
        if (last_base + 24 < wq_data.size()) begin
            check("cancel_l5", wq_data[last_base + 5], 64'hFF);
            check("cancel_l4", wq_data[last_base + 4], 64'h0);
        end

        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_case($sformatf("rand%0d", r));
        end

        // start held high: one done every 103 cycles, two parity+update read
        // sweeps (0..24 twice) per run.
        fill_random();
        load_mem();
        rbase = rq_addr.size();
        dbase = done_cyc.size();
        s     = ncyc;
        start = 1'b1;
        repeat (260) @(negedge clk);
        start = 1'b0;
        check("hold_done_count", 64'(done_cyc.size() - dbase), 64'd2);
        if (done_cyc.size() - dbase >= 2) begin
            check("hold_first_done", 64'(done_cyc[dbase] - s), 64'd102);
            check("hold_period", 64'(done_cyc[dbase + 1] - done_cyc[dbase]), 64'd103);
        end
        check("hold_reads", 64'(rq_addr.size() - rbase >= 100), 64'd1);
        for (int i = 0; i < 100; i++) begin
            if (rbase + i < rq_addr.size())
                check($sformatf("hold_rd%0d", i), 64'(rq_addr[rbase + i]), 64'(i % 25));
        end
        k = 0;
        while (!ready && k < 300) begin
            @(negedge clk);
            k++;
        end
        check("hold_idle", 64'(ready), 64'd1);

        // Reset in the middle of the update pass.
        fill_random();
        load_mem();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (k < 60) begin
            @(negedge clk);
            k++;
        end
        check("mid_busy", 64'(ready), 64'd0);
        #1;
        reset = 1'b1;
        #1;
        check("mid_rst_wr_en", 64'(wr_en), 64'd0);
        check("mid_rst_rd_en", 64'(rd_en), 64'd0);
        check("mid_rst_ready", 64'(ready), 64'd1);
        check("mid_rst_done",  64'(done),  64'd0);
        @(negedge clk);
        reset = 1'b0;

        fill_random();
        run_case("after_rst");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
